regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised general-purpose register file for the decode stage.
- Provides NUM_RD registered read ports and two write ports (WB0, WB1) with write-first bypass.
- Keeps a per-register busy scoreboard so that decode can detect pending producers.
- After reset, a sequential init sweep clears the storage before the block accepts traffic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1 entry 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high once the init sweep is complete.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data.
- rd_busy  out  NUM_RD  registered busy flag of each addressed entry.
- reg_wr0  in  1  write enable, write port 0.
- reg_wr_addr0  in  ADDR_W  write address, port 0.
- reg_wr_data0  in  DATA_W  write data, port 0.
- reg_wr1  in  1  write enable, write port 1.
- reg_wr_addr1  in  ADDR_W  write address, port 1.
- reg_wr_data1  in  DATA_W  write data, port 1.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  ADDR_W  address to reserve.

Behaviour:
- States: INIT and RUN. Reset forces INIT with init_cnt=0.
- Reset values: ready=0, rd_data=0, rd_busy=0, all busy bits=0.
- INIT:
  - Each cycle writes 0 to entry init_cnt, then increments the counter.
  - After entry DEPTH-1 is written, the block moves to RUN; ready rises exactly DEPTH cycles after reset deasserts.
  - In INIT, writes and reserves are ignored, and rd_data/rd_busy stay 0.
- Reset asserted mid-INIT or in RUN restarts the sweep at entry 0.
- RUN read:
  - 1-cycle latency: rd_data[k] at edge N+1 = value of entry rd_addr[k] after the writes of edge N are applied (write-first).
  - Bypass precedence: port 1 data, then port 0 data, then stored value.
- RUN write:
  - On posedge, each enabled port stores its data.
  - Both ports writing the same address: port 1 wins.
  - A write to entry 0 with ZERO_REG=1 is dropped, and reads of entry 0 return 0.
- Scoreboard:
  - An enabled write to address A clears busy[A].
  - rsv_en sets busy[rsv_addr].
  - Reserve and write to the same address in one cycle: busy ends set (reserve wins); data is still written.
  - Reserving an already-busy entry leaves it set.
  - rd_busy[k] follows the same write-first rule and timing as rd_data[k].
  - rsv_addr=0 with ZERO_REG=1 is ignored.
- Widths: no arithmetic on data. init_cnt is ADDR_W+1 bits so the terminal count is detectable without wrap.
- Out-of-range addresses cannot occur (full decode).

Test Plan:
- Reset, then hold 1 for 3 cycles and release -> ready low for 32 cycles, high on the 32nd edge after release; reads of entries 0..31 all return 0.
- RUN: write 32'hDEADBEEF to r7 via port 0, with rd_addr0=7 on the same edge -> rd_data0=32'hDEADBEEF one cycle later (bypass); rd_addr1=7 on the next cycle also returns it.
- Same edge: port 0 writes r3=5 and port 1 writes r3=9 -> r3 reads 9. Port 0 writes r0=0x55 -> r0 reads 0.
- rsv_en r12 -> rd_busy=1 for r12 next cycle. Port 1 writes r12 -> busy clears. Reserve and write r12 on the same edge -> busy stays 1 and data is updated.
- Assert reset at init_cnt=10 -> ready stays low a full 32 cycles from the release; a write to r4 issued during INIT is not visible after ready.
- NUM_RD=4, ADDR_W=4 instance: 4 concurrent reads of distinct written entries return the correct data; ready rises after 16 cycles.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport: multi-port register file with write-first bypass, busy scoreboard and post-reset clear sweep
module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     reg_wr0,
  input  logic [ADDR_W-1:0]        reg_wr_addr0,
  input  logic [DATA_W-1:0]        reg_wr_data0,
  input  logic                     reg_wr1,
  input  logic [ADDR_W-1:0]        reg_wr_addr1,
  input  logic [DATA_W-1:0]        reg_wr_data1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t st, st_nx;
  logic [ADDR_W:0] init_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic we0, we1, rsv;
  assign ready = st == RUN;
  assign we0 = reg_wr0 && !(ZERO_REG && (reg_wr_addr0 == '0));
  assign we1 = reg_wr1 && !(ZERO_REG && (reg_wr_addr1 == '0));
  assign rsv = rsv_en && !(ZERO_REG && (rsv_addr == '0));
  always_comb begin
    st_nx = st;
    st_nx = (st == INIT && init_cnt == (ADDR_W+1)'(DEPTH-1)) ? RUN : st;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= INIT;
      init_cnt <= '0;
      busy <= '0;
    end else begin
      st <= st_nx;
      if (st == INIT) init_cnt <= init_cnt + 1'b1;
      else begin
        if (we0) busy[reg_wr_addr0] <= 1'b0;
        if (we1) busy[reg_wr_addr1] <= 1'b0;
        if (rsv) busy[rsv_addr] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (st == INIT) mem[init_cnt[ADDR_W-1:0]] <= '0;
    else if (!reset) begin
      if (we0) mem[reg_wr_addr0] <= reg_wr_data0;
      if (we1) mem[reg_wr_addr1] <= reg_wr_data1;
    end
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] q;
    logic z, h0, h1, b;
    assign a = rd_addr[g*ADDR_W +: ADDR_W];
    assign z = ZERO_REG && (a == '0);
    assign h0 = reg_wr0 && (reg_wr_addr0 == a);
    assign h1 = reg_wr1 && (reg_wr_addr1 == a);
    always_ff @(posedge clk) begin
      if (reset || st == INIT) begin
        q <= '0;
        b <= 1'b0;
      end else begin
        q <= z ? '0 : h1 ? reg_wr_data1 : h0 ? reg_wr_data0 : mem[a];
        b <= !z && ((rsv_en && (rsv_addr == a)) || (!(h0 || h1) && busy[a]));
      end
    end
    assign rd_data[g*DATA_W +: DATA_W] = q;
    assign rd_busy[g] = b;
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: randomized and directed check of regfile_multiport against a behavioural model
module tb_regfile_multiport;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset;
  logic ready;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic wr0, wr1, rsv_en;
  logic [4:0] wa0, wa1, rsv_addr;
  logic [31:0] wd0, wd1;
  logic b_ready;
  logic [15:0] b_rd_addr;
  logic [127:0] b_rd_data;
  logic [3:0] b_rd_busy;
  logic b_wr0, b_wr1, b_rsv_en;
  logic [3:0] b_wa0, b_wa1, b_rsv_addr;
  logic [31:0] b_wd0, b_wd1;
  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .reg_wr0(wr0), .reg_wr_addr0(wa0), .reg_wr_data0(wd0),
    .reg_wr1(wr1), .reg_wr_addr1(wa1), .reg_wr_data1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );
  regfile_multiport #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .ready(b_ready), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .reg_wr0(b_wr0), .reg_wr_addr0(b_wa0), .reg_wr_data0(b_wd0),
    .reg_wr1(b_wr1), .reg_wr_addr1(b_wa1), .reg_wr_data1(b_wd1),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr)
  );
  int n_cmp = 0;
  int n_miss = 0;
  bit armed = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [31:0] m_reg [32];
  bit m_busy [32];
  int since = 0;
  logic [63:0] e_data = '0;
  logic [1:0] e_busy = '0;
  logic e_ready = 0;
  always @(posedge clk) begin
    if (reset) begin
      since = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      e_data = '0;
      e_busy = '0;
    end else if (since < 32) begin
      m_reg[since] = '0;
      since++;
      e_data = '0;
      e_busy = '0;
    end else begin
      if (wr0 && wa0 != 0) m_reg[wa0] = wd0;
      if (wr1 && wa1 != 0) m_reg[wa1] = wd1;
      if (wr0) m_busy[wa0] = 0;
      if (wr1) m_busy[wa1] = 0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
      for (int k = 0; k < 2; k++) begin
        e_data[k*32 +: 32] = m_reg[rd_addr[k*5 +: 5]];
        e_busy[k] = m_busy[rd_addr[k*5 +: 5]];
      end
    end
    e_ready = since >= 32;
  end
  always @(negedge clk) if (armed) begin
    chk("ready", 64'(ready), 64'(e_ready));
    chk("rd_data0", 64'(rd_data[31:0]), 64'(e_data[31:0]));
    chk("rd_data1", 64'(rd_data[63:32]), 64'(e_data[63:32]));
    chk("rd_busy", 64'(rd_busy), 64'(e_busy));
  end
  task automatic idle();
    wr0 = 0; wr1 = 0; rsv_en = 0;
    b_wr0 = 0; b_wr1 = 0; b_rsv_en = 0;
  endtask
  task automatic wait_ready(input int exp_a, input int exp_b, input int wr_at);
    int ca = 0;
    int cb = 0;
    for (int c = 1; c <= 100 && (ca == 0 || cb == 0); c++) begin
      @(negedge clk);
      idle();
      if (ready && ca == 0) ca = c;
      if (b_ready && cb == 0) cb = c;
      if (c == wr_at) begin
        wr0 = 1; wa0 = 5'd4; wd0 = 32'h4444_4444;
        rd_addr = {5'd4, 5'd4};
      end
    end
    chk("ready_latency_a", 64'(ca), 64'(exp_a));
    if (exp_b > 0) chk("ready_latency_b", 64'(cb), 64'(exp_b));
  endtask
  initial begin
    reset = 1;
    rd_addr = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; rsv_addr = '0;
    b_rd_addr = '0; b_wa0 = '0; b_wa1 = '0; b_wd0 = '0; b_wd1 = '0; b_rsv_addr = '0;
    idle();
    @(posedge clk);
    armed = 1;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    reset = 0;
    wait_ready(32, 16, 0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = {5'(2*i+1), 5'(2*i)};
      @(negedge clk);
      if (i > 0) chk("sweep_zero", rd_data, 64'd0);
    end
    @(negedge clk);
    chk("sweep_zero_last", rd_data, 64'd0);
    wr0 = 1; wa0 = 5'd7; wd0 = 32'hDEAD_BEEF; rd_addr = {5'd0, 5'd7};
    @(negedge clk);
    idle();
    chk("bypass_p0_r7", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    rd_addr = {5'd7, 5'd0};
    @(negedge clk);
    chk("stored_p1_r7", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
    wr0 = 1; wa0 = 5'd3; wd0 = 32'd5; wr1 = 1; wa1 = 5'd3; wd1 = 32'd9; rd_addr = {5'd0, 5'd3};
    @(negedge clk);
    idle();
    chk("p1_wins_r3", 64'(rd_data[31:0]), 64'd9);
    wr0 = 1; wa0 = 5'd0; wd0 = 32'h55; rd_addr = {5'd3, 5'd0};
    @(negedge clk);
    idle();
    chk("r0_bypass_zero", 64'(rd_data[31:0]), 64'd0);
    chk("r3_stored", 64'(rd_data[63:32]), 64'd9);
    @(negedge clk);
    chk("r0_stored_zero", 64'(rd_data[31:0]), 64'd0);
    rsv_en = 1; rsv_addr = 5'd12; rd_addr = {5'd0, 5'd12};
    @(negedge clk);
    idle();
    chk("rsv_busy_r12", 64'(rd_busy[0]), 64'd1);
    wr1 = 1; wa1 = 5'd12; wd1 = 32'h1234;
    @(negedge clk);
    idle();
    chk("wr_clears_busy", 64'(rd_busy[0]), 64'd0);
    chk("wr_r12_data", 64'(rd_data[31:0]), 64'h1234);
    rsv_en = 1; rsv_addr = 5'd12; wr0 = 1; wa0 = 5'd12; wd0 = 32'hABCD;
    @(negedge clk);
    idle();
    chk("rsv_wins_busy", 64'(rd_busy[0]), 64'd1);
    chk("rsv_wr_data", 64'(rd_data[31:0]), 64'hABCD);
    rsv_en = 1; rsv_addr = 5'd0; rd_addr = {5'd12, 5'd0};
    @(negedge clk);
    idle();
    chk("r0_never_busy", 64'(rd_busy), 64'd2);
    b_wr0 = 1; b_wa0 = 4'd1; b_wd0 = 32'h1111; b_wr1 = 1; b_wa1 = 4'd5; b_wd1 = 32'h5555;
    @(negedge clk);
    b_wr0 = 1; b_wa0 = 4'd9; b_wd0 = 32'h9999; b_wr1 = 1; b_wa1 = 4'd15; b_wd1 = 32'hFFFF;
    @(negedge clk);
    idle();
    b_rd_addr = {4'd15, 4'd9, 4'd5, 4'd1};
    @(negedge clk);
    chk("b_port0", 64'(b_rd_data[31:0]), 64'h1111);
    chk("b_port1", 64'(b_rd_data[63:32]), 64'h5555);
    chk("b_port2", 64'(b_rd_data[95:64]), 64'h9999);
    chk("b_port3", 64'(b_rd_data[127:96]), 64'hFFFF);
    for (int i = 0; i < 1500; i++) begin
      wr0 = 1'($urandom); wr1 = 1'($urandom); rsv_en = ($urandom % 3) == 0;
      wa0 = ($urandom % 2) ? 5'($urandom % 8) : 5'($urandom);
      wa1 = ($urandom % 2) ? 5'($urandom % 8) : 5'($urandom);
      rsv_addr = ($urandom % 2) ? 5'($urandom % 8) : 5'($urandom);
      rd_addr = ($urandom % 2) ? {5'($urandom % 8), 5'($urandom % 8)} : 10'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      @(negedge clk);
    end
    idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_init_reset_ready", 64'(ready), 64'd0);
    reset = 0;
    wait_ready(32, 16, 20);
    rd_addr = {5'd7, 5'd4};
    @(negedge clk);
    chk("init_write_dropped", 64'(rd_data[31:0]), 64'd0);
    chk("reset_clears_r7", 64'(rd_data[63:32]), 64'd0);
    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule
